// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetches sequential bytes from a 1-cycle-latency RAM
// into a DEPTH-byte FIFO and presents the head byte and its address to the decoder.
module prefetch_queue #(
    parameter int DEPTH    = 6,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int RESET_IP = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_addr,
    input  logic              deq,
    output logic              q_valid,
    output logic [DATA_W-1:0] q_data,
    output logic [ADDR_W-1:0] q_ip,
    output logic [3:0]        q_count
);
    localparam int                PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_IP);
    localparam logic [PTR_W-1:0]  LAST_PTR   = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem_q [0:(1<<PTR_W)-1];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [3:0]        count_q, count_d;
    logic              pending_q, pending_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic [ADDR_W-1:0] q_ip_q, q_ip_d;
    logic              issue, push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Space is reserved for the in-flight byte, so a returning read always fits.
    assign issue = !rst && !flush && (({1'b0, count_q} + 5'(pending_q)) < 5'(DEPTH));
    assign push  = pending_q && !flush;
    assign pop   = deq && (count_q != 4'd0) && !flush;

    always_comb begin
        count_d      = count_q;
        pending_d    = issue;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        fetch_addr_d = fetch_addr_q;
        q_ip_d       = q_ip_q;
        if (flush) begin
            count_d      = '0;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            fetch_addr_d = flush_addr;
            q_ip_d       = flush_addr;
        end else begin
            count_d = count_q + {3'b000, push} - {3'b000, pop};
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
                q_ip_d   = q_ip_q + ADDR_W'(1);
            end
            if (issue) begin
                fetch_addr_d = fetch_addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q      <= '0;
            pending_q    <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            fetch_addr_q <= RESET_ADDR;
            q_ip_q       <= RESET_ADDR;
        end else begin
            count_q      <= count_d;
            pending_q    <= pending_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            fetch_addr_q <= fetch_addr_d;
            q_ip_q       <= q_ip_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= mem_data;
        end
    end

    assign mem_rd   = issue;
    assign mem_addr = fetch_addr_q;
    assign q_valid  = (count_q != 4'd0);
    assign q_data   = q_valid ? mem_q[rd_ptr_q] : '0;
    assign q_ip     = q_ip_q;
    assign q_count  = count_q;

    assert property (@(posedge clk) disable iff (rst) count_q <= 4'(DEPTH));

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue with a behavioural 1-cycle-latency RAM
// whose content is RAM[a] = a + 0x10.
module tb_prefetch_queue;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic [7:0] mem_data = 8'h00;
    logic       flush = 1'b0;
    logic [7:0] flush_addr = 8'h00;
    logic       deq = 1'b0;
    logic       q_valid;
    logic [7:0] q_data;
    logic [7:0] q_ip;
    logic [3:0] q_count;

    int n_checks = 0;
    int n_errors = 0;

    prefetch_queue #(.DEPTH(6), .ADDR_W(8), .DATA_W(8), .RESET_IP(0)) dut (
        .clk(clk), .rst(rst),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
        .flush(flush), .flush_addr(flush_addr), .deq(deq),
        .q_valid(q_valid), .q_data(q_data), .q_ip(q_ip), .q_count(q_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem_addr + 8'h10;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks += 6;
        if (q_valid  !== 1'b0)  begin n_errors++; $display("FAIL reset_q_valid: got %b, expected 0", q_valid); end
        if (q_count  !== 4'd0)  begin n_errors++; $display("FAIL reset_q_count: got %0d, expected 0", q_count); end
        if (mem_rd   !== 1'b0)  begin n_errors++; $display("FAIL reset_mem_rd: got %b, expected 0", mem_rd); end
        if (q_data   !== 8'h00) begin n_errors++; $display("FAIL reset_q_data: got %h, expected 00", q_data); end
        if (mem_addr !== 8'h00) begin n_errors++; $display("FAIL reset_mem_addr: got %h, expected 00", mem_addr); end
        if (q_ip     !== 8'h00) begin n_errors++; $display("FAIL reset_q_ip: got %h, expected 00", q_ip); end
        $display("test_reset: outputs at reset values checked");
    endtask

    task automatic test_fill();
        int reads = 0;
        rst = 1'b0;
        #1;
        n_checks += 2;
        if (mem_rd   !== 1'b1)  begin n_errors++; $display("FAIL fill_first_rd: got %b, expected 1", mem_rd); end
        if (mem_addr !== 8'h00) begin n_errors++; $display("FAIL fill_first_addr: got %h, expected 00", mem_addr); end
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (mem_rd === 1'b1) begin
                n_checks++;
                if (mem_addr !== 8'(reads)) begin n_errors++; $display("FAIL fill_addr: got %h, expected %h", mem_addr, 8'(reads)); end
                reads++;
            end
            if (cyc >= 6) begin
                n_checks++;
                if (mem_rd !== 1'b0) begin n_errors++; $display("FAIL fill_rd_stops cyc %0d: got %b, expected 0", cyc, mem_rd); end
            end
            if (cyc == 1) begin
                n_checks++;
                if (q_valid !== 1'b0) begin n_errors++; $display("FAIL fill_latency_early: got q_valid %b, expected 0", q_valid); end
            end
            if (cyc == 2) begin
                n_checks += 3;
                if (q_valid !== 1'b1)  begin n_errors++; $display("FAIL fill_q_valid: got %b, expected 1", q_valid); end
                if (q_data  !== 8'h10) begin n_errors++; $display("FAIL fill_q_data: got %h, expected 10", q_data); end
                if (q_ip    !== 8'h00) begin n_errors++; $display("FAIL fill_q_ip: got %h, expected 00", q_ip); end
            end
            step();
        end
        n_checks += 2;
        if (reads   !== 6)    begin n_errors++; $display("FAIL fill_read_count: got %0d, expected 6", reads); end
        if (q_count !== 4'd6) begin n_errors++; $display("FAIL fill_q_count: got %0d, expected 6", q_count); end
        $display("test_fill: %0d reads issued, q_count=%0d", reads, q_count);
    endtask

    task automatic test_drain();
        for (int k = 0; k < 10; k++) begin
            deq = 1'b1;
            #1;
            n_checks += 4;
            if (q_valid !== 1'b1)         begin n_errors++; $display("FAIL drain_valid pop %0d: got %b, expected 1", k, q_valid); end
            if (q_data  !== 8'(8'h10 + k)) begin n_errors++; $display("FAIL drain_data pop %0d: got %h, expected %h", k, q_data, 8'(8'h10 + k)); end
            if (q_ip    !== 8'(k))        begin n_errors++; $display("FAIL drain_ip pop %0d: got %h, expected %h", k, q_ip, 8'(k)); end
            if (q_count > 4'd6)           begin n_errors++; $display("FAIL drain_count pop %0d: got %0d, expected <=6", k, q_count); end
            step();
        end
        deq = 1'b0;
        #1;
        n_checks += 2;
        if (q_ip   !== 8'h0A) begin n_errors++; $display("FAIL drain_final_ip: got %h, expected 0a", q_ip); end
        if (q_data !== 8'h1A) begin n_errors++; $display("FAIL drain_final_data: got %h, expected 1a", q_data); end
        $display("test_drain: 10 pops, head now ip=%h data=%h", q_ip, q_data);
    endtask

    task automatic test_flush_inflight();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        n_checks += 2;
        if (mem_rd   !== 1'b1)  begin n_errors++; $display("FAIL flush_pre_rd: got %b, expected 1", mem_rd); end
        if (mem_addr !== 8'h01) begin n_errors++; $display("FAIL flush_pre_addr: got %h, expected 01", mem_addr); end
        flush = 1'b1;
        flush_addr = 8'hFE;
        #1;
        n_checks++;
        if (mem_rd !== 1'b0) begin n_errors++; $display("FAIL flush_cycle_rd: got %b, expected 0", mem_rd); end
        step();
        flush = 1'b0;
        #1;
        n_checks += 4;
        if (q_valid  !== 1'b0)  begin n_errors++; $display("FAIL flush_q_valid: got %b, expected 0", q_valid); end
        if (q_count  !== 4'd0)  begin n_errors++; $display("FAIL flush_q_count: got %0d, expected 0", q_count); end
        if (mem_rd   !== 1'b1)  begin n_errors++; $display("FAIL flush_resume_rd: got %b, expected 1", mem_rd); end
        if (mem_addr !== 8'hFE) begin n_errors++; $display("FAIL flush_addr_fe: got %h, expected fe", mem_addr); end
        step();
        n_checks += 2;
        if (mem_addr !== 8'hFF) begin n_errors++; $display("FAIL flush_addr_ff: got %h, expected ff", mem_addr); end
        if (q_count  !== 4'd0)  begin n_errors++; $display("FAIL flush_no_stale: got %0d, expected 0", q_count); end
        step();
        n_checks += 4;
        if (mem_addr !== 8'h00) begin n_errors++; $display("FAIL flush_addr_wrap: got %h, expected 00", mem_addr); end
        if (q_valid  !== 1'b1)  begin n_errors++; $display("FAIL flush_head_valid: got %b, expected 1", q_valid); end
        if (q_data   !== 8'h0E) begin n_errors++; $display("FAIL flush_head_data: got %h, expected 0e", q_data); end
        if (q_ip     !== 8'hFE) begin n_errors++; $display("FAIL flush_head_ip: got %h, expected fe", q_ip); end
        $display("test_flush_inflight: head ip=%h data=%h", q_ip, q_data);
    endtask

    task automatic test_deq_empty();
        rst = 1'b1;
        step();
        step();
        deq = 1'b1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (q_valid !== 1'b0) begin n_errors++; $display("FAIL deq_empty_valid0: got %b, expected 0", q_valid); end
        step();
        n_checks += 2;
        if (q_valid !== 1'b0)  begin n_errors++; $display("FAIL deq_empty_valid1: got %b, expected 0", q_valid); end
        if (q_ip    !== 8'h00) begin n_errors++; $display("FAIL deq_empty_ip: got %h, expected 00", q_ip); end
        deq = 1'b0;
        step();
        n_checks += 3;
        if (q_valid !== 1'b1)  begin n_errors++; $display("FAIL deq_empty_first_valid: got %b, expected 1", q_valid); end
        if (q_data  !== 8'h10) begin n_errors++; $display("FAIL deq_empty_first_data: got %h, expected 10", q_data); end
        if (q_ip    !== 8'h00) begin n_errors++; $display("FAIL deq_empty_first_ip: got %h, expected 00", q_ip); end
        $display("test_deq_empty: first byte %h at ip %h", q_data, q_ip);
    endtask

    task automatic test_flush_deq();
        step();
        step();
        n_checks++;
        if (q_count !== 4'd3) begin n_errors++; $display("FAIL flush_deq_pre_count: got %0d, expected 3", q_count); end
        flush = 1'b1;
        deq = 1'b1;
        flush_addr = 8'h40;
        #1;
        n_checks++;
        if (mem_rd !== 1'b0) begin n_errors++; $display("FAIL flush_deq_rd: got %b, expected 0", mem_rd); end
        step();
        flush = 1'b0;
        deq = 1'b0;
        #1;
        n_checks += 5;
        if (q_count  !== 4'd0)  begin n_errors++; $display("FAIL flush_deq_count: got %0d, expected 0", q_count); end
        if (q_valid  !== 1'b0)  begin n_errors++; $display("FAIL flush_deq_valid: got %b, expected 0", q_valid); end
        if (q_ip     !== 8'h40) begin n_errors++; $display("FAIL flush_deq_ip: got %h, expected 40", q_ip); end
        if (mem_rd   !== 1'b1)  begin n_errors++; $display("FAIL flush_deq_resume_rd: got %b, expected 1", mem_rd); end
        if (mem_addr !== 8'h40) begin n_errors++; $display("FAIL flush_deq_addr: got %h, expected 40", mem_addr); end
        step();
        step();
        n_checks += 2;
        if (q_data !== 8'h50) begin n_errors++; $display("FAIL flush_deq_head_data: got %h, expected 50", q_data); end
        if (q_ip   !== 8'h40) begin n_errors++; $display("FAIL flush_deq_head_ip: got %h, expected 40", q_ip); end
        $display("test_flush_deq: head ip=%h data=%h", q_ip, q_data);
    endtask

    task automatic test_async_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        repeat (5) step();
        n_checks += 2;
        if (q_count !== 4'd4) begin n_errors++; $display("FAIL areset_pre_count: got %0d, expected 4", q_count); end
        if (mem_rd  !== 1'b1) begin n_errors++; $display("FAIL areset_pre_rd: got %b, expected 1", mem_rd); end
        #2;
        rst = 1'b1;
        #1;
        n_checks += 6;
        if (q_valid  !== 1'b0)  begin n_errors++; $display("FAIL areset_q_valid: got %b, expected 0", q_valid); end
        if (q_count  !== 4'd0)  begin n_errors++; $display("FAIL areset_q_count: got %0d, expected 0", q_count); end
        if (mem_rd   !== 1'b0)  begin n_errors++; $display("FAIL areset_mem_rd: got %b, expected 0", mem_rd); end
        if (q_data   !== 8'h00) begin n_errors++; $display("FAIL areset_q_data: got %h, expected 00", q_data); end
        if (mem_addr !== 8'h00) begin n_errors++; $display("FAIL areset_mem_addr: got %h, expected 00", mem_addr); end
        if (q_ip     !== 8'h00) begin n_errors++; $display("FAIL areset_q_ip: got %h, expected 00", q_ip); end
        #1;
        rst = 1'b0;
        #1;
        n_checks += 2;
        if (mem_rd   !== 1'b1)  begin n_errors++; $display("FAIL areset_restart_rd: got %b, expected 1", mem_rd); end
        if (mem_addr !== 8'h00) begin n_errors++; $display("FAIL areset_restart_addr: got %h, expected 00", mem_addr); end
        step();
        n_checks += 2;
        if (q_count !== 4'd0) begin n_errors++; $display("FAIL areset_stale_count: got %0d, expected 0", q_count); end
        if (q_valid !== 1'b0) begin n_errors++; $display("FAIL areset_stale_valid: got %b, expected 0", q_valid); end
        step();
        n_checks += 3;
        if (q_count !== 4'd1)  begin n_errors++; $display("FAIL areset_first_count: got %0d, expected 1", q_count); end
        if (q_data  !== 8'h10) begin n_errors++; $display("FAIL areset_first_data: got %h, expected 10", q_data); end
        if (q_ip    !== 8'h00) begin n_errors++; $display("FAIL areset_first_ip: got %h, expected 00", q_ip); end
        $display("test_async_reset: restart head ip=%h data=%h", q_ip, q_data);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_flush_inflight();
        test_deq_empty();
        test_flush_deq();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/prefetch_queue.md
Name: prefetch_queue

Overview:
- 8086-style instruction prefetch queue (BIU stage) between program RAM and the instruction decoder; the decoder feeds the ALU.
- Fetches bytes sequentially from a synchronous 1-cycle-latency RAM read port into a DEPTH-byte FIFO.
- Presents the head byte and its address to the decoder.
- A flush (jump/branch) discards queued and in-flight bytes and restarts fetch at a new address.

Parameters:
DEPTH, 6, queue capacity in bytes (2..15)
ADDR_W, 8, RAM address width; addresses wrap modulo 2^ADDR_W
DATA_W, 8, byte width
RESET_IP, 0, fetch/head address after reset

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
mem_addr  output  ADDR_W  RAM read address, valid when mem_rd=1
mem_rd  output  1  RAM read request this cycle
mem_data  input  DATA_W  RAM read data, valid in the cycle after mem_rd
flush  input  1  discard queue, restart at flush_addr
flush_addr  input  ADDR_W  new fetch/head address, sampled when flush=1
deq  input  1  decoder consumes head byte this cycle
q_valid  output  1  queue non-empty
q_data  output  DATA_W  head byte, valid when q_valid=1
q_ip  output  ADDR_W  address of head byte
q_count  output  4  bytes currently queued (0..DEPTH)

Behaviour:
Reset (async, any time, including mid-fetch):
- count=0, pending=0, fetch_addr=RESET_IP, q_ip=RESET_IP.
- Outputs: q_valid=0, q_count=0, mem_rd=0, q_data=0, mem_addr=RESET_IP.

Issue:
- mem_rd = !rst && !flush && (count + pending < DEPTH), combinational from registered count/pending.
- mem_addr = fetch_addr.
- deq in the same cycle does not free space for issue (no deq->mem_rd path).
- On issue: fetch_addr <= fetch_addr+1 (wraps 2^ADDR_W-1 -> 0), pending <= 1. Otherwise pending <= 0.
- Back-to-back issue every cycle is allowed.

Return:
- If pending=1 at an edge and flush=0, mem_data is written at the tail.
- A byte read in cycle N is visible at q_data in cycle N+2 if the queue was empty.
- Capacity is never exceeded by construction. An assertion checks that count never exceeds DEPTH.

Dequeue:
- deq=1 with q_valid=1: head advances, q_ip <= q_ip+1 (wrapping).
- deq=1 with q_valid=0: ignored, no state change.
- Simultaneous enqueue+dequeue: count unchanged, FIFO order kept, including at count=DEPTH.
- Internal read/write pointers wrap modulo DEPTH.

Flush (highest priority):
- At the edge: count <= 0, pending <= 0.
- The returning in-flight byte is dropped, even though mem_data is driven.
- fetch_addr <= flush_addr, q_ip <= flush_addr. A simultaneous deq is ignored.
- mem_rd=0 in the flush cycle. Fetch resumes the next cycle at flush_addr.
- Consecutive flush cycles: the last flush_addr wins.

Ordering:
- Bytes reach q_data strictly in address order from the last reset/flush.
- q_ip always equals the address of q_data.

Test Plan:
1. Reset release, RAM[i]=0x10+i, deq=0:
   - mem_rd=1, addr 0x00 in the first cycle.
   - q_valid rises 2 cycles later with q_data=0x10, q_ip=0x00.
   - Fetch stops with q_count=6 after exactly 6 reads (addr 0x00..0x05). mem_rd stays 0 thereafter.
2. Full queue, deq=1 held for 10 cycles:
   - q_data sequence 0x10,0x11,... with no gap after the initial drain latency.
   - q_count never exceeds 6. q_ip increments by 1 per pop.
3. Flush with flush_addr=0xFE while a read is pending:
   - The next cycle shows q_valid=0, q_count=0; the in-flight byte is never enqueued.
   - The following reads use addr 0xFE, 0xFF, 0x00 (wrap).
   - q_ip=0xFE with q_data=RAM[0xFE].
4. deq=1 on an empty queue right after reset:
   - Ignored; q_ip stays 0x00.
   - The first enqueued byte is 0x10, not skipped.
5. flush and deq asserted together at q_count=3, flush_addr=0x40:
   - Flush wins: q_count=0, q_ip=0x40. deq has no effect.
   - Next fetch addr=0x40.
6. rst pulsed asynchronously mid-cycle with q_count=4 and pending=1:
   - Outputs go to reset values immediately, without waiting for a clock edge.
   - After release, fetch restarts at RESET_IP and the stale return is not enqueued.
